// File: rtl/lector_sensor_spi.sv
// lector_sensor_spi
// SPI master (mode 0) that periodically reads a 16-bit digital temperature
// sensor frame and keeps the last valid signed 11-bit temperature.
//
// Frame (MSB first): [15:5] signed temperature, [4:1] ignored, [0] must be 0.
// Frames with bit 0 set are rejected and flagged on error_trama.
//
// Optional build macro FILTRO_PROMEDIO_EN: temp_salida becomes the floor mean
// of the last 4 valid samples; temp_valida then lags the frame end by 1 cycle.
//
// Ports:
//   clk          system clock
//   arst_n       asynchronous active-low reset
//   habilitar    enables periodic read frames
//   spi_miso     serial data from the sensor (synchronized internally)
//   spi_sclk     SPI clock, idle low
//   spi_cs_n     chip select, active low
//   temp_salida  last valid temperature (signed)
//   temp_valida  one-cycle pulse when temp_salida updates
//   error_trama  one-cycle pulse on a rejected frame
//   ocupado      high while a frame is in progress
module lector_sensor_spi #(
   parameter int unsigned CLK_DIV         = 4,
   parameter int unsigned PERIODO_MUESTRA = 1000
) (
   input  logic               clk,
   input  logic               arst_n,
   input  logic               habilitar,
   input  logic               spi_miso,
   output logic               spi_sclk,
   output logic               spi_cs_n,
   output logic signed [10:0] temp_salida,
   output logic               temp_valida,
   output logic               error_trama,
   output logic               ocupado
);

   localparam int unsigned EspW = (PERIODO_MUESTRA > 1) ? $clog2(PERIODO_MUESTRA) : 1;
   localparam logic [7:0]      DivMax = 8'(CLK_DIV - 1);
   localparam logic [EspW-1:0] EspMax = EspW'(PERIODO_MUESTRA - 1);

   typedef enum logic [2:0] {
      StReposo,
      StSeleccion,
      StTransferencia,
      StFin,
      StEspera
   } estado_t;

   estado_t          r_estado, w_estado_d;
   logic [7:0]       r_div, w_div_d;
   logic [3:0]       r_bit, w_bit_d;
   logic             r_fase, w_fase_d;
   logic [EspW-1:0]  r_esp, w_esp_d;
   logic [15:0]      r_sr, w_sr_d;
   logic             r_miso_s1, r_miso_s2;
   logic             r_cs_n, r_ocupado;
   logic             r_valida, r_error;
   logic signed [10:0] r_temp;
   logic             w_fin_div, w_fin_ok, w_fin_err, w_activo_d;
   logic signed [10:0] w_temp_trama;

   assign w_fin_div    = (r_div == DivMax);
   assign w_temp_trama = $signed(r_sr[15:5]);
   assign w_activo_d   = (w_estado_d == StSeleccion) || (w_estado_d == StTransferencia) ||
                         (w_estado_d == StFin);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_miso_s1 <= 1'b0;
         r_miso_s2 <= 1'b0;
      end else begin
         r_miso_s1 <= spi_miso;
         r_miso_s2 <= r_miso_s1;
      end
   end

   always_comb begin
      w_estado_d = r_estado;
      w_div_d    = r_div;
      w_bit_d    = r_bit;
      w_fase_d   = r_fase;
      w_esp_d    = r_esp;
      w_sr_d     = r_sr;
      w_fin_ok   = 1'b0;
      w_fin_err  = 1'b0;
      case (r_estado)
         StReposo: begin
            if (habilitar) begin
               w_estado_d = StSeleccion;
               w_div_d    = '0;
            end
         end
         StSeleccion: begin
            if (w_fin_div) begin
               w_estado_d = StTransferencia;
               w_div_d    = '0;
               w_bit_d    = '0;
               w_fase_d   = 1'b0;
            end else begin
               w_div_d = r_div + 8'd1;
            end
         end
         StTransferencia: begin
            if (w_fin_div) begin
               w_div_d = '0;
               if (!r_fase) begin
                  w_fase_d = 1'b1;
               end else begin
                  // Sample at the end of the high phase: data changed on the previous fall.
                  w_fase_d = 1'b0;
                  w_sr_d   = {r_sr[14:0], r_miso_s2};
                  if (r_bit == 4'd15) begin
                     w_estado_d = StFin;
                     w_bit_d    = '0;
                  end else begin
                     w_bit_d = r_bit + 4'd1;
                  end
               end
            end else begin
               w_div_d = r_div + 8'd1;
            end
         end
         StFin: begin
            if (w_fin_div) begin
               w_div_d    = '0;
               w_esp_d    = '0;
               w_estado_d = StEspera;
               if (!r_sr[0]) w_fin_ok  = 1'b1;
               else          w_fin_err = 1'b1;
            end else begin
               w_div_d = r_div + 8'd1;
            end
         end
         StEspera: begin
            if (r_esp == EspMax) begin
               w_esp_d    = '0;
               w_estado_d = habilitar ? StSeleccion : StReposo;
            end else begin
               w_esp_d = r_esp + EspW'(1);
            end
         end
         default: w_estado_d = StReposo;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_estado  <= StReposo;
         r_div     <= '0;
         r_bit     <= '0;
         r_fase    <= 1'b0;
         r_esp     <= '0;
         r_sr      <= '0;
         r_cs_n    <= 1'b1;
         r_ocupado <= 1'b0;
         r_error   <= 1'b0;
      end else begin
         r_estado  <= w_estado_d;
         r_div     <= w_div_d;
         r_bit     <= w_bit_d;
         r_fase    <= w_fase_d;
         r_esp     <= w_esp_d;
         r_sr      <= w_sr_d;
         r_cs_n    <= !w_activo_d;
         r_ocupado <= w_activo_d;
         r_error   <= w_fin_err;
      end
   end

`ifdef FILTRO_PROMEDIO_EN
   logic signed [10:0] r_muestra;
   logic               r_muestra_ok;
   logic signed [10:0] r_buf [4];
   logic               r_cargado;
   logic signed [10:0] w_buf_n [4];
   logic signed [12:0] w_suma;
   logic signed [10:0] w_media;

   always_comb begin
      // First sample after reset fills the whole window so the mean starts at it.
      if (r_cargado) begin
         w_buf_n[0] = r_muestra;
         w_buf_n[1] = r_buf[0];
         w_buf_n[2] = r_buf[1];
         w_buf_n[3] = r_buf[2];
      end else begin
         w_buf_n[0] = r_muestra;
         w_buf_n[1] = r_muestra;
         w_buf_n[2] = r_muestra;
         w_buf_n[3] = r_muestra;
      end
      w_suma  = {{2{w_buf_n[0][10]}}, w_buf_n[0]} + {{2{w_buf_n[1][10]}}, w_buf_n[1]} +
                {{2{w_buf_n[2][10]}}, w_buf_n[2]} + {{2{w_buf_n[3][10]}}, w_buf_n[3]};
      w_media = 11'(w_suma >>> 2);
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_muestra    <= '0;
         r_muestra_ok <= 1'b0;
         r_buf        <= '{default: '0};
         r_cargado    <= 1'b0;
         r_temp       <= '0;
         r_valida     <= 1'b0;
      end else begin
         r_muestra_ok <= w_fin_ok;
         if (w_fin_ok) r_muestra <= w_temp_trama;
         r_valida <= r_muestra_ok;
         if (r_muestra_ok) begin
            r_buf     <= w_buf_n;
            r_cargado <= 1'b1;
            r_temp    <= w_media;
         end
      end
   end
`else
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_temp   <= '0;
         r_valida <= 1'b0;
      end else begin
         r_valida <= w_fin_ok;
         if (w_fin_ok) r_temp <= w_temp_trama;
      end
   end
`endif

   assign spi_sclk    = r_fase;
   assign spi_cs_n    = r_cs_n;
   assign ocupado     = r_ocupado;
   assign temp_salida = r_temp;
   assign temp_valida = r_valida;
   assign error_trama = r_error;

endmodule

// File: tb/tb_lector_sensor_spi.sv
module tb_lector_sensor_spi;

   localparam int unsigned CLK_DIV = 4;
   localparam int unsigned PERIODO = 30;
   localparam int FRAME_CYC = 34 * CLK_DIV;
   localparam int RES_BOUND = FRAME_CYC + PERIODO + 20;
`ifdef FILTRO_PROMEDIO_EN
   localparam int EXTRA    = 1;
   localparam int EXP_DROP = 11;
`else
   localparam int EXTRA    = 0;
   localparam int EXP_DROP = 45;
`endif

   logic clk = 1'b0;
   logic arst_n = 1'b0;
   logic habilitar = 1'b0;
   logic spi_miso;
   logic spi_sclk, spi_cs_n;
   logic signed [10:0] temp_salida;
   logic temp_valida, error_trama, ocupado;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lector_sensor_spi #(
      .CLK_DIV        (CLK_DIV),
      .PERIODO_MUESTRA(PERIODO)
   ) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .habilitar  (habilitar),
      .spi_miso   (spi_miso),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .temp_salida(temp_salida),
      .temp_valida(temp_valida),
      .error_trama(error_trama),
      .ocupado    (ocupado)
   );

   // Sensor model: presents bit 15 when selected, advances on every SCLK fall.
   logic [15:0] tx_frame = 16'h0000;
   int n_bajadas = 0;
   always @(posedge spi_cs_n or negedge spi_sclk) begin
      if (spi_cs_n) n_bajadas = 0;
      else          n_bajadas = n_bajadas + 1;
   end
   assign spi_miso = (n_bajadas < 16) ? tx_frame[4'(15 - n_bajadas)] : 1'b0;

   typedef struct {
      logic [15:0] frame;
      logic        exp_v;
      logic        exp_e;
      int          exp_t;
   } vec_t;
   vec_t tbl [8];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_result(output logic got_v, output logic got_e, output logic both);
      got_v = 1'b0;
      got_e = 1'b0;
      both  = 1'b0;
      for (int i = 0; i < RES_BOUND; i++) begin
         @(negedge clk);
         if (temp_valida && error_trama) both = 1'b1;
         if (temp_valida || error_trama) begin
            got_v = temp_valida;
            got_e = error_trama;
            break;
         end
      end
   endtask

   task automatic wait_cs_fall(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < RES_BOUND; i++) begin
         @(negedge clk);
         if (!spi_cs_n) begin
            seen = 1'b1;
            break;
         end
      end
      check(name, int'(seen), 1);
   endtask

   task automatic wait_rises(input string name, input int n);
      logic prev;
      int   rises;
      prev  = spi_sclk;
      rises = 0;
      for (int i = 0; i < FRAME_CYC && rises < n; i++) begin
         @(negedge clk);
         if (spi_sclk && !prev) rises++;
         prev = spi_sclk;
      end
      check(name, rises, n);
   endtask

   task automatic run_vec(input string name, input logic [15:0] frame, input logic ev,
                          input logic ee, input int et);
      logic v, e, b;
      tx_frame = frame;
      wait_result(v, e, b);
      check({name, " valida"}, int'(v), int'(ev));
      check({name, " error"}, int'(e), int'(ee));
      check({name, " exclusivos"}, int'(b), 0);
      check({name, " temp"}, int'(temp_salida), et);
   endtask

   initial begin
      logic prev;
      int   rises, altos, lat, activos;

`ifdef FILTRO_PROMEDIO_EN
      tbl[0] = '{16'h0500, 1'b1, 1'b0, 40};
      tbl[1] = '{16'h0500, 1'b1, 1'b0, 40};
      tbl[2] = '{16'h0500, 1'b1, 1'b0, 40};
      tbl[3] = '{16'h0580, 1'b1, 1'b0, 41};
      tbl[4] = '{16'h05A1, 1'b0, 1'b1, 41};
      tbl[5] = '{16'h0000, 1'b1, 1'b0, 31};
      tbl[6] = '{16'h8000, 1'b1, 1'b0, -235};
      tbl[7] = '{16'h7FE0, 1'b1, 1'b0, 10};
`else
      tbl[0] = '{16'hF9C0, 1'b1, 1'b0, -50};
      tbl[1] = '{16'h7FE0, 1'b1, 1'b0, 1023};
      tbl[2] = '{16'h8000, 1'b1, 1'b0, -1024};
      tbl[3] = '{16'h05BE, 1'b1, 1'b0, 45};
      tbl[4] = '{16'hF9C0, 1'b1, 1'b0, -50};
      tbl[5] = '{16'h05A1, 1'b0, 1'b1, -50};
      tbl[6] = '{16'h0001, 1'b0, 1'b1, -50};
      tbl[7] = '{16'hFFFE, 1'b1, 1'b0, -1};
`endif

      // Reset state
      repeat (3) @(negedge clk);
      check("rst cs_n", int'(spi_cs_n), 1);
      check("rst sclk", int'(spi_sclk), 0);
      check("rst temp", int'(temp_salida), 0);
      check("rst valida", int'(temp_valida), 0);
      check("rst error", int'(error_trama), 0);
      check("rst ocupado", int'(ocupado), 0);
      arst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("reposo cs_n", int'(spi_cs_n), 1);

      // First frame: timing of CS, SCLK and the result pulse
      tx_frame  = 16'h05A0;
      habilitar = 1'b1;
      @(negedge clk);
      check("cs cae 1 ciclo", int'(spi_cs_n), 0);
      check("ocupado en trama", int'(ocupado), 1);
      prev  = spi_sclk;
      rises = 0;
      altos = 0;
      lat   = -1;
      for (int k = 1; k <= FRAME_CYC + 20; k++) begin
         @(negedge clk);
         if (spi_sclk && !prev) rises++;
         if (spi_sclk) altos++;
         prev = spi_sclk;
         if (temp_valida) begin
            lat = k;
            break;
         end
      end
      check("latencia valida", lat, FRAME_CYC + EXTRA);
      check("pulsos sclk", rises, 16);
      check("ciclos sclk alto", altos, 16 * CLK_DIV);
      check("primera temp", int'(temp_salida), 45);
      check("cs_n tras trama", int'(spi_cs_n), 1);
      check("ocupado tras trama", int'(ocupado), 0);

      // Table of frames, starting from a fresh reset
      @(negedge clk);
      arst_n   = 1'b0;
      tx_frame = tbl[0].frame;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      for (int i = 0; i < 8; i++)
         run_vec($sformatf("vec%0d", i), tbl[i].frame, tbl[i].exp_v, tbl[i].exp_e, tbl[i].exp_t);

      // habilitar dropped mid-frame: frame completes, then idle
      tx_frame = 16'h05A0;
      wait_cs_fall("drop cs cae");
      wait_rises("drop bit 8", 8);
      habilitar = 1'b0;
      run_vec("drop", 16'h05A0, 1'b1, 1'b0, EXP_DROP);
      repeat (PERIODO + 5) @(negedge clk);
      check("drop cs_n reposo", int'(spi_cs_n), 1);
      check("drop ocupado", int'(ocupado), 0);
      activos = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (spi_sclk || !spi_cs_n || temp_valida || error_trama) activos++;
      end
      check("drop sin actividad", activos, 0);

      // Asynchronous reset at bit 10
      habilitar = 1'b1;
      wait_cs_fall("rst cs cae");
      wait_rises("rst bit 10", 10);
      arst_n = 1'b0;
      #1;
      check("rst medio cs_n", int'(spi_cs_n), 1);
      check("rst medio sclk", int'(spi_sclk), 0);
      check("rst medio temp", int'(temp_salida), 0);
      check("rst medio ocupado", int'(ocupado), 0);
      repeat (2) @(negedge clk);
      tx_frame = 16'hF9C0;
      arst_n   = 1'b1;
      run_vec("tras rst", 16'hF9C0, 1'b1, 1'b0, -50);

      // Negative samples after reset: floor behaviour in the filtered build
      @(negedge clk);
      arst_n   = 1'b0;
      tx_frame = 16'hFFE0;
      repeat (2) @(negedge clk);
      arst_n = 1'b1;
      run_vec("neg1", 16'hFFE0, 1'b1, 1'b0, -1);
      run_vec("neg2", 16'hFFC0, 1'b1, 1'b0, -2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
